// File: rtl/hcm_pkg.sv
// Shared definitions for the HCM row responder: geometry, derived widths,
// the controller state type and the row popcount helper.
package hcm_pkg;

    localparam int NROWS   = 1024;
    localparam int ROWBITS = $clog2(NROWS);
    localparam int NCOLS   = 16;
    localparam int COLBITS = $clog2(NCOLS);
    localparam int HITBITS = $clog2(NCOLS + 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic logic [HITBITS-1:0] popcount(input logic [NCOLS-1:0] v);
        logic [HITBITS-1:0] n;
        n = '0;
        for (int i = 0; i < NCOLS; i++) begin
            n = n + HITBITS'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/hcm_row_responder_if.sv
// Request/response bundle between the road-finding initiator and the row responder.
// HCM_STATS_EN adds the statWrites / statNewSSIDs counters to the bundle.
interface hcm_row_responder_if;
    import hcm_pkg::*;

    logic               eventClear;
    logic               writeRow;
    logic [ROWBITS-1:0] inputRowToWrite;
    logic [COLBITS-1:0] inputColToWrite;
    logic               SSIDIsNew;
    logic               readRow;
    logic [ROWBITS-1:0] inputRowToRead;
    logic               writeReady;
    logic               readReady;
    logic               readValid;
    logic [ROWBITS-1:0] rowPassed;
    logic [NCOLS-1:0]   rowReadOutput;
    logic [HITBITS-1:0] nHits;
    logic               busy;
`ifdef HCM_STATS_EN
    logic [31:0]        statWrites;
    logic [31:0]        statNewSSIDs;
`endif

    modport master (
        output eventClear, writeRow, inputRowToWrite, inputColToWrite, SSIDIsNew,
               readRow, inputRowToRead,
        input  writeReady, readReady, readValid, rowPassed, rowReadOutput, nHits, busy
`ifdef HCM_STATS_EN
        , input statWrites, statNewSSIDs
`endif
    );

    modport slave (
        input  eventClear, writeRow, inputRowToWrite, inputColToWrite, SSIDIsNew,
               readRow, inputRowToRead,
        output writeReady, readReady, readValid, rowPassed, rowReadOutput, nHits, busy
`ifdef HCM_STATS_EN
        , output statWrites, statNewSSIDs
`endif
    );

endinterface

// File: rtl/hcm_bram_dp.sv
// Row storage: one write port and two registered read ports with 1-cycle latency.
// A read that collides with a write at the same edge returns the old contents.
module hcm_bram_dp
    import hcm_pkg::*;
#(
    parameter int DEPTH = NROWS,
    parameter int WIDTH = NCOLS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddrA,
    output logic [WIDTH-1:0] o_rdataA,
    input  logic [AW-1:0]    i_raddrB,
    output logic [WIDTH-1:0] o_rdataB
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdataA;
    logic [WIDTH-1:0] r_rdataB;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdataA <= r_mem[i_raddrA];
        r_rdataB <= r_mem[i_raddrB];
    end

    assign o_rdataA = r_rdataA;
    assign o_rdataB = r_rdataB;

endmodule

// File: rtl/hcm_row_responder.sv
// HCM row responder: per-row hit bitmaps with 2-stage read-modify-write updates,
// 2-cycle pipelined reads and a hardware clear sweep. HCM_STATS_EN adds write counters.
module hcm_row_responder
    import hcm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    hcm_row_responder_if.slave bus
);

    state_t             r_state;
    state_t             w_nextState;
    logic [ROWBITS-1:0] r_sweepRow;
    logic [ROWBITS-1:0] w_nextSweepRow;
    logic               w_sweeping;
    logic               w_ready;
    logic               w_wrRowOk;
    logic               w_rdRowOk;
    logic               w_wrAccept;
    logic               w_rdAccept;

    logic               r_wrValid;
    logic [ROWBITS-1:0] r_wrRow;
    logic [COLBITS-1:0] r_wrCol;
    logic               r_wrNew;
    logic               r_rdValid;
    logic [ROWBITS-1:0] r_rdRow;
    logic               r_lastValid;
    logic [ROWBITS-1:0] r_lastRow;
    logic [NCOLS-1:0]   r_lastData;

    logic [NCOLS-1:0]   w_ramRdA;
    logic [NCOLS-1:0]   w_ramRdB;
    logic [NCOLS-1:0]   w_wrOld;
    logic [NCOLS-1:0]   w_wrNew;
    logic [NCOLS-1:0]   w_rdData;
    logic               w_ramWe;
    logic [ROWBITS-1:0] w_ramWaddr;
    logic [NCOLS-1:0]   w_ramWdata;

    logic               r_readValid;
    logic [ROWBITS-1:0] r_rowPassed;
    logic [NCOLS-1:0]   r_rowReadOutput;
    logic [HITBITS-1:0] r_nHits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= CLEAR;
            r_sweepRow <= '0;
        end else begin
            r_state    <= w_nextState;
            r_sweepRow <= w_nextSweepRow;
        end
    end

    // eventClear during a sweep rewinds it, so a full NROWS pass always follows the last pulse.
    always_comb begin
        w_nextState    = r_state;
        w_nextSweepRow = r_sweepRow;
        w_ready        = 1'b0;
        case (r_state)
            CLEAR: begin
                if (bus.eventClear) begin
                    w_nextSweepRow = '0;
                end else if (r_sweepRow == ROWBITS'(NROWS - 1)) begin
                    w_nextState    = IDLE;
                    w_nextSweepRow = '0;
                end else begin
                    w_nextSweepRow = r_sweepRow + ROWBITS'(1);
                end
            end
            IDLE: begin
                w_ready = ~bus.eventClear;
                if (bus.eventClear) begin
                    w_nextState    = CLEAR;
                    w_nextSweepRow = '0;
                end
            end
            default: begin
                w_nextState = CLEAR;
            end
        endcase
    end

    assign w_sweeping     = (r_state == CLEAR);
    assign bus.busy       = w_sweeping;
    assign bus.writeReady = w_ready;
    assign bus.readReady  = w_ready;

    generate
        if (NROWS == (1 << ROWBITS)) begin : g_fullRange
            assign w_wrRowOk = 1'b1;
            assign w_rdRowOk = 1'b1;
        end else begin : g_partialRange
            assign w_wrRowOk = (32'(bus.inputRowToWrite) < 32'(NROWS));
            assign w_rdRowOk = (32'(bus.inputRowToRead) < 32'(NROWS));
        end
    endgenerate

    assign w_wrAccept = bus.writeRow & w_ready & w_wrRowOk;
    assign w_rdAccept = bus.readRow & w_ready & w_rdRowOk;

    // r_last* holds the row written at the previous edge, which the read-first RAM cannot yet return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrValid   <= 1'b0;
            r_wrRow     <= '0;
            r_wrCol     <= '0;
            r_wrNew     <= 1'b0;
            r_rdValid   <= 1'b0;
            r_rdRow     <= '0;
            r_lastValid <= 1'b0;
            r_lastRow   <= '0;
            r_lastData  <= '0;
        end else begin
            r_wrValid   <= w_wrAccept;
            r_wrRow     <= bus.inputRowToWrite;
            r_wrCol     <= bus.inputColToWrite;
            r_wrNew     <= bus.SSIDIsNew;
            r_rdValid   <= w_rdAccept;
            r_rdRow     <= bus.inputRowToRead;
            r_lastValid <= r_wrValid & ~w_sweeping;
            r_lastRow   <= r_wrRow;
            r_lastData  <= w_wrNew;
        end
    end

    assign w_wrOld = (r_lastValid && (r_lastRow == r_wrRow)) ? r_lastData : w_ramRdA;
    assign w_wrNew = (r_wrNew ? '0 : w_wrOld) | (NCOLS'(1) << r_wrCol);
    assign w_rdData = (r_lastValid && (r_lastRow == r_rdRow)) ? r_lastData : w_ramRdB;

    assign w_ramWe    = w_sweeping | r_wrValid;
    assign w_ramWaddr = w_sweeping ? r_sweepRow : r_wrRow;
    assign w_ramWdata = w_sweeping ? '0 : w_wrNew;

    hcm_bram_dp #(
        .DEPTH (NROWS),
        .WIDTH (NCOLS)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_ramWe),
        .i_waddr  (w_ramWaddr),
        .i_wdata  (w_ramWdata),
        .i_raddrA (bus.inputRowToWrite),
        .o_rdataA (w_ramRdA),
        .i_raddrB (bus.inputRowToRead),
        .o_rdataB (w_ramRdB)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readValid     <= 1'b0;
            r_rowPassed     <= '0;
            r_rowReadOutput <= '0;
            r_nHits         <= '0;
        end else begin
            r_readValid <= r_rdValid;
            if (r_rdValid) begin
                r_rowPassed     <= r_rdRow;
                r_rowReadOutput <= w_rdData;
                r_nHits         <= popcount(w_rdData);
            end
        end
    end

    assign bus.readValid     = r_readValid;
    assign bus.rowPassed     = r_rowPassed;
    assign bus.rowReadOutput = r_rowReadOutput;
    assign bus.nHits         = r_nHits;

`ifdef HCM_STATS_EN
    logic [31:0] r_statWrites;
    logic [31:0] r_statNewSSIDs;

    // Counters restart with every sweep and stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_statWrites   <= '0;
            r_statNewSSIDs <= '0;
        end else if (bus.eventClear) begin
            r_statWrites   <= '0;
            r_statNewSSIDs <= '0;
        end else if (w_wrAccept) begin
            if (r_statWrites != 32'hFFFF_FFFF) begin
                r_statWrites <= r_statWrites + 32'd1;
            end
            if (bus.SSIDIsNew && (r_statNewSSIDs != 32'hFFFF_FFFF)) begin
                r_statNewSSIDs <= r_statNewSSIDs + 32'd1;
            end
        end
    end

    assign bus.statWrites   = r_statWrites;
    assign bus.statNewSSIDs = r_statNewSSIDs;
`endif

endmodule
